// File: rtl/kernel_scan_scheduler.sv
// Stage sequencer for the edge-detection filter chain: raster-scans the image
// once per filter stage, feeds kernel columns to the active sub-module and places its results.
module kernel_scan_scheduler #(
    parameter int IMG_DIM   = 20,
    parameter int ADDR_W    = 9,
    parameter int DRAIN_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              mod_readable,
    input  logic              wb_ack,
    output logic [2:0]        op,
    output logic              kernel5,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    output logic [ADDR_W-1:0] rd_addr3,
    output logic [ADDR_W-1:0] rd_addr4,
    output logic              rd_valid,
    output logic              col_first,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wb_req,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {
        S_IDLE, S_SET_OP, S_SCAN, S_DRAIN, S_WRITE_BACK, S_DONE
    } state_t;

    localparam int                DRAIN_W   = $clog2(DRAIN_MAX + 1);
    localparam logic [ADDR_W-1:0] DIM       = ADDR_W'(IMG_DIM);
    localparam logic [ADDR_W-1:0] DIM_M1    = ADDR_W'(IMG_DIM - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW3 = ADDR_W'(IMG_DIM - 3);
    localparam logic [ADDR_W-1:0] LAST_ROW5 = ADDR_W'(IMG_DIM - 5);
    localparam logic [ADDR_W-1:0] RES3      = ADDR_W'((IMG_DIM - 2) * (IMG_DIM - 2));
    localparam logic [ADDR_W-1:0] RES5      = ADDR_W'((IMG_DIM - 4) * (IMG_DIM - 4));

    state_t                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [ADDR_W-1:0]      row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0]      orow_q, orow_d, ocol_q, ocol_d;
    logic [ADDR_W-1:0]      res_cnt_q, res_cnt_d;
    logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
    logic [4:0][ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic                   rd_valid_q, rd_valid_d, col_first_q, col_first_d;
    logic                   wb_req_q, wb_req_d, busy_q, busy_d;
    logic                   done_q, done_d, err_q, err_d;

    // Kernel geometry of the current stage: last window row/column index (R-1),
    // result total (R*R) and the half-kernel offset placing a result at its centre pixel.
    logic              k5;
    logic [ADDR_W-1:0] last_win, res_total, half, col_base;
    logic              accept;

    assign k5        = (op_q == 3'd2);
    assign last_win  = k5 ? LAST_ROW5 : LAST_ROW3;
    assign res_total = k5 ? RES5 : RES3;
    assign half      = k5 ? ADDR_W'(2) : ADDR_W'(1);
    assign col_base  = row_q * DIM + col_q;
    assign accept    = mod_readable && (state_q == S_SCAN || state_q == S_DRAIN);

    // The write strobe follows mod_readable combinationally; surplus results are refused.
    assign wr_en   = accept && (res_cnt_q != res_total);
    assign wr_addr = wr_en ? (orow_q + half) * DIM + ocol_q + half : '0;

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case infers a latch.
        state_d     = state_q;
        op_d        = op_q;
        row_d       = row_q;
        col_d       = col_q;
        orow_d      = orow_q;
        ocol_d      = ocol_q;
        res_cnt_d   = res_cnt_q;
        drain_cnt_d = drain_cnt_q;
        rd_addr_d   = rd_addr_q;
        rd_valid_d  = 1'b0;
        col_first_d = col_first_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SET_OP;
                    op_d    = 3'd1;
                    err_d   = 1'b0;
                end
            end
            S_SET_OP: begin
                row_d       = '0;
                col_d       = '0;
                orow_d      = '0;
                ocol_d      = '0;
                res_cnt_d   = '0;
                drain_cnt_d = '0;
                state_d     = S_SCAN;
            end
            S_SCAN: begin
                if (!stall) begin
                    rd_valid_d  = 1'b1;
                    col_first_d = (col_q == '0);
                    for (int k = 0; k < 5; k++) begin
                        rd_addr_d[k] = (k < 3 || k5) ? col_base + ADDR_W'(k * IMG_DIM) : '0;
                    end
                    if (col_q == DIM_M1) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                        if (row_q == last_win) state_d = S_DRAIN;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (res_cnt_q == res_total || drain_cnt_q == DRAIN_W'(DRAIN_MAX - 1)) begin
                    if (res_cnt_q != res_total) err_d = 1'b1;
                    state_d = (op_q == 3'd5) ? S_DONE : S_WRITE_BACK;
                end
            end
            S_WRITE_BACK: begin
                if (wb_ack) begin
                    op_d    = op_q + 1'b1;
                    state_d = S_SET_OP;
                end
            end
            S_DONE: begin
                op_d    = 3'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            if (res_cnt_q == res_total) begin
                err_d = 1'b1;
            end else begin
                res_cnt_d = res_cnt_q + 1'b1;
                if (ocol_q == last_win) begin
                    ocol_d = '0;
                    orow_d = orow_q + 1'b1;
                end else begin
                    ocol_d = ocol_q + 1'b1;
                end
            end
        end
    end

    // Status strobes are registered off the next state so they line up with it.
    assign wb_req_d = (state_d == S_WRITE_BACK);
    assign busy_d   = (state_d != S_IDLE);
    assign done_d   = (state_d == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            orow_q      <= '0;
            ocol_q      <= '0;
            res_cnt_q   <= '0;
            drain_cnt_q <= '0;
            rd_addr_q   <= '0;
            rd_valid_q  <= 1'b0;
            col_first_q <= 1'b0;
            wb_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            row_q       <= row_d;
            col_q       <= col_d;
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            res_cnt_q   <= res_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            rd_addr_q   <= rd_addr_d;
            rd_valid_q  <= rd_valid_d;
            col_first_q <= col_first_d;
            wb_req_q    <= wb_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign op        = op_q;
    assign kernel5   = k5;
    assign rd_addr0  = rd_addr_q[0];
    assign rd_addr1  = rd_addr_q[1];
    assign rd_addr2  = rd_addr_q[2];
    assign rd_addr3  = rd_addr_q[3];
    assign rd_addr4  = rd_addr_q[4];
    assign rd_valid  = rd_valid_q;
    assign col_first = col_first_q;
    assign wb_req    = wb_req_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_kernel_scan_scheduler.sv
// Bench for kernel_scan_scheduler: a sub-module/write-back model plus an index-based
// reference for every issued column and every placed result, driven by a scenario table.
module tb_kernel_scan_scheduler;
    localparam int IMG_DIM   = 20;
    localparam int ADDR_W    = 9;
    localparam int DRAIN_MAX = 15;

    logic              clk;
    logic              reset, start, stall, mod_readable, wb_ack;
    logic [2:0]        op;
    logic              kernel5, rd_valid, col_first, wr_en, wb_req, busy, done, err;
    logic [ADDR_W-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3, rd_addr4, wr_addr;

    kernel_scan_scheduler #(.IMG_DIM(IMG_DIM), .ADDR_W(ADDR_W), .DRAIN_MAX(DRAIN_MAX)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .mod_readable(mod_readable), .wb_ack(wb_ack), .op(op), .kernel5(kernel5),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_addr3(rd_addr3), .rd_addr4(rd_addr4), .rd_valid(rd_valid),
        .col_first(col_first), .wr_en(wr_en), .wr_addr(wr_addr), .wb_req(wb_req),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        int              stall_mode;  // 0 none, 1 random, 2 seven cycles mid row 5 of stage 1
        int              drop_op;     // stage whose final result is withheld
        int              surplus_op;  // stage that receives extra results
        int              ack_lat;     // wb_req cycles up to and including the ack cycle
        int              busy_op;     // stage during which start and a stray wb_ack are pulsed
        bit              exp_err;
        logic [4:0][8:0] exp_wr;      // expected writes for stages 1..5
    } vec_t;

    function automatic vec_t mk(input int sm, input int dr, input int su, input int ack,
                                input int bo, input bit e, input logic [4:0][8:0] w);
        vec_t v;
        v.stall_mode = sm; v.drop_op = dr; v.surplus_op = su; v.ack_lat = ack;
        v.busy_op = bo; v.exp_err = e; v.exp_wr = w;
        return v;
    endfunction

    function automatic int k_of(input int o);
        return (o == 2) ? 5 : 3;
    endfunction

    // Scenario configuration (written by the main sequence only)
    int   cfg_stall = 0, cfg_drop = 0, cfg_surplus = 0, cfg_ack = 1;
    logic inject_rd = 1'b0, inject_ack = 1'b0;

    // Model / scoreboard state (written by the model process only)
    int issues[6], writes[6], produced[6];
    int wr_first[6], wr_last[6];
    int rd_first1[5], rd_col20[5], rd_last1[5], rd_first2[5];
    int last_op = 0, wb_len = 0, since = 0, low_run = 0, stall_left = 0, done_cnt = 0;
    int last_a0 = 0, last_cf = 0;
    bit prev_wb = 0, pipe0 = 0, pipe1 = 0;
    int m_o, m_k, m_n, m_r, m_c, m_e, m_m, m_rr, m_h, m_total;
    int cur_a[5];
    bit m_trig;

    function automatic int exp_err_now(input int o);
        return ((cfg_drop != 0 && o >= cfg_drop) || (cfg_surplus != 0 && o >= cfg_surplus)) ? 1 : 0;
    endfunction

    // Sub-module + write-back responder and reference checker, sampled on the falling edge.
    initial begin
        mod_readable = 1'b0; wb_ack = 1'b0; stall = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pipe0 = 0; pipe1 = 0; mod_readable = 1'b0; wb_ack = 1'b0; stall = 1'b0;
                wb_len = 0; prev_wb = 0; last_op = 0; stall_left = 0; since = 0; low_run = 0;
            end else begin
                cur_a[0] = int'(rd_addr0); cur_a[1] = int'(rd_addr1); cur_a[2] = int'(rd_addr2);
                cur_a[3] = int'(rd_addr3); cur_a[4] = int'(rd_addr4);
                m_o = int'(op);
                m_k = k_of(m_o);
                m_trig = 0;
                if (m_o != last_op) begin
                    check("op_sequence", m_o, (last_op == 5) ? 0 : last_op + 1);
                    if (m_o >= 1 && m_o <= 5) begin
                        issues[m_o] = 0; writes[m_o] = 0; produced[m_o] = 0;
                    end
                    last_op = m_o;
                end
                if (done) done_cnt++;
                if (m_o >= 1 && m_o <= 5) begin
                    m_total = (m_k == 5) ? 320 : 360;
                    if (rd_valid) begin
                        m_n = issues[m_o];
                        m_r = m_n / IMG_DIM;
                        m_c = m_n % IMG_DIM;
                        for (int j = 0; j < 5; j++)
                            check($sformatf("rd_addr%0d op%0d col#%0d", j, m_o, m_n), cur_a[j],
                                  (j < m_k) ? (m_r + j) * IMG_DIM + m_c : 0);
                        check("col_first", int'(col_first), (m_c == 0) ? 1 : 0);
                        check("kernel5", int'(kernel5), (m_o == 2) ? 1 : 0);
                        if (cfg_stall == 2 && m_o == 1 && m_n == 110)
                            check("stall_gap_cycles", low_run, 7);
                        for (int j = 0; j < 5; j++) begin
                            if (m_o == 1 && m_n == 0)   rd_first1[j] = cur_a[j];
                            if (m_o == 1 && m_n == 19)  rd_col20[j]  = cur_a[j];
                            if (m_o == 1 && m_n == 359) rd_last1[j]  = cur_a[j];
                            if (m_o == 2 && m_n == 0)   rd_first2[j] = cur_a[j];
                        end
                        issues[m_o]++;
                        low_run = 0; since = 0;
                        last_a0 = cur_a[0]; last_cf = int'(col_first);
                        m_trig = (m_c >= m_k - 1) || (cfg_surplus == m_o && m_c >= m_k - 2);
                        m_e = (IMG_DIM - m_k + 1) * (IMG_DIM - m_k + 1);
                        if (m_trig && cfg_drop == m_o && produced[m_o] == m_e - 1) m_trig = 0;
                        if (m_trig) produced[m_o]++;
                        if (cfg_stall == 2 && m_o == 1 && issues[m_o] == 110) stall_left = 7;
                    end else begin
                        low_run++; since++;
                        if (issues[m_o] > 0 && issues[m_o] < m_total) begin
                            check("frozen_rd_addr0", cur_a[0], last_a0);
                            check("frozen_col_first", int'(col_first), last_cf);
                        end
                    end
                end
                if (wb_req) begin
                    if (!prev_wb) begin
                        if (cfg_drop == m_o) check("drain_timeout_cycles", since, DRAIN_MAX);
                        check($sformatf("err_at_wb op%0d", m_o), int'(err), exp_err_now(m_o));
                    end
                    wb_len++;
                end else if (prev_wb) begin
                    check("wb_req_len", wb_len, cfg_ack);
                    wb_len = 0;
                end
                prev_wb = wb_req;
                wb_ack = (wb_req && wb_len >= cfg_ack) || inject_ack;
                mod_readable = pipe1 | inject_rd;
                pipe1 = pipe0;
                pipe0 = m_trig;
                if (stall_left > 0) begin
                    stall = 1'b1;
                    stall_left--;
                end else begin
                    stall = (cfg_stall == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
                end
                #1;
                if (wr_en) begin
                    check("wr_en_without_readable", int'(mod_readable), 1);
                    if (m_o >= 1 && m_o <= 5) begin
                        m_m  = writes[m_o];
                        m_rr = IMG_DIM - m_k + 1;
                        m_h  = (m_k - 1) / 2;
                        check($sformatf("wr_addr op%0d res#%0d", m_o, m_m), int'(wr_addr),
                              (m_m / m_rr + m_h) * IMG_DIM + m_m % m_rr + m_h);
                        if (m_m == 0) wr_first[m_o] = int'(wr_addr);
                        wr_last[m_o] = int'(wr_addr);
                        writes[m_o]++;
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " op"}, int'(op), 0);
        check({tag, " kernel5"}, int'(kernel5), 0);
        check({tag, " rd_addr0"}, int'(rd_addr0), 0);
        check({tag, " rd_addr1"}, int'(rd_addr1), 0);
        check({tag, " rd_addr2"}, int'(rd_addr2), 0);
        check({tag, " rd_addr3"}, int'(rd_addr3), 0);
        check({tag, " rd_addr4"}, int'(rd_addr4), 0);
        check({tag, " rd_valid"}, int'(rd_valid), 0);
        check({tag, " col_first"}, int'(col_first), 0);
        check({tag, " wr_en"}, int'(wr_en), 0);
        check({tag, " wr_addr"}, int'(wr_addr), 0);
        check({tag, " wb_req"}, int'(wb_req), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " err"}, int'(err), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk); #2; start = 1'b1;
        @(negedge clk); #2; start = 1'b0;
    endtask

    task automatic run_scenario(input vec_t v, input int idx);
        int  base;
        bit  got_done, pulsed;
        cfg_stall = v.stall_mode; cfg_drop = v.drop_op; cfg_surplus = v.surplus_op;
        cfg_ack = v.ack_lat;
        base = done_cnt;
        got_done = 0; pulsed = 0;
        pulse_start();
        for (int cyc = 0; cyc < 30000 && !got_done; cyc++) begin
            @(negedge clk); #2;
            start = 1'b0; inject_ack = 1'b0;
            if (done) got_done = 1;
            else if (v.busy_op != 0 && !pulsed && int'(op) == v.busy_op && rd_valid) begin
                start = 1'b1; inject_ack = 1'b1; pulsed = 1;
            end
        end
        check($sformatf("vec%0d run_completes", idx), int'(got_done), 1);
        repeat (3) @(negedge clk);
        #2; start = 1'b0; inject_ack = 1'b0;
        check($sformatf("vec%0d done_pulses", idx), done_cnt - base, 1);
        for (int o = 1; o <= 5; o++) begin
            check($sformatf("vec%0d writes op%0d", idx, o), writes[o], int'(v.exp_wr[o-1]));
            check($sformatf("vec%0d issues op%0d", idx, o), issues[o], (o == 2) ? 320 : 360);
        end
        check($sformatf("vec%0d err", idx), int'(err), int'(v.exp_err));
        check($sformatf("vec%0d op_idle", idx), int'(op), 0);
        check($sformatf("vec%0d busy_idle", idx), int'(busy), 0);
    endtask

    localparam logic [4:0][8:0] WR_NORM = {9'd324, 9'd324, 9'd324, 9'd256, 9'd324};
    localparam logic [4:0][8:0] WR_DROP = {9'd324, 9'd324, 9'd324, 9'd256, 9'd323};

    vec_t vecs[6];
    bit   reached;

    initial begin
        reset = 1'b1; start = 1'b0;
        vecs[0] = mk(0, 0, 0, 1,  0, 1'b0, WR_NORM);
        vecs[1] = mk(2, 0, 0, 1,  0, 1'b0, WR_NORM);
        vecs[2] = mk(1, 0, 0, 3,  0, 1'b0, WR_NORM);
        vecs[3] = mk(0, 1, 0, 1,  0, 1'b1, WR_DROP);
        vecs[4] = mk(1, 0, 3, 2,  0, 1'b1, WR_NORM);
        vecs[5] = mk(0, 0, 0, 10, 2, 1'b0, WR_NORM);

        repeat (2) @(negedge clk);
        #2;
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_scenario(vecs[i], i);
            if (i == 0) begin
                check("s1 first rd0", rd_first1[0], 0);
                check("s1 first rd1", rd_first1[1], 20);
                check("s1 first rd2", rd_first1[2], 40);
                check("s1 col20 rd0", rd_col20[0], 19);
                check("s1 col20 rd1", rd_col20[1], 39);
                check("s1 col20 rd2", rd_col20[2], 59);
                check("s1 last rd0", rd_last1[0], 359);
                check("s1 last rd1", rd_last1[1], 379);
                check("s1 last rd2", rd_last1[2], 399);
                check("s2 first rd3", rd_first2[3], 60);
                check("s2 first rd4", rd_first2[4], 80);
                check("s1 first wr", wr_first[1], 21);
                check("s1 last wr", wr_last[1], 378);
                check("s2 first wr", wr_first[2], 42);
                check("s2 last wr", wr_last[2], 357);
            end
        end

        // Reset in the middle of the stage-3 scan
        cfg_stall = 1; cfg_drop = 0; cfg_surplus = 0; cfg_ack = 1;
        pulse_start();
        reached = 0;
        for (int cyc = 0; cyc < 20000 && !reached; cyc++) begin
            @(negedge clk); #2;
            if (int'(op) == 3 && issues[3] >= 100) reached = 1;
        end
        check("reach_stage3_scan", int'(reached), 1);
        reset = 1'b1;
        #1;
        check_all_zero("reset_mid_scan");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #2;
            check("in_reset wb_req", int'(wb_req), 0);
            check("in_reset done", int'(done), 0);
        end
        reset = 1'b0;
        cfg_stall = 0;
        repeat (5) @(negedge clk);
        #2;
        check("after_reset op", int'(op), 0);
        check("after_reset busy", int'(busy), 0);

        // Results and acks while idle are ignored
        inject_rd = 1'b1; inject_ack = 1'b1;
        @(negedge clk); #2;
        check("idle readable wr_en", int'(wr_en), 0);
        inject_rd = 1'b0; inject_ack = 1'b0;
        @(negedge clk); #2;
        check("idle ack op", int'(op), 0);
        check("idle ack wb_req", int'(wb_req), 0);

        run_scenario(vecs[0], 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
